// File: rtl/invert_scheduler_pkg.sv
// Shared types and defaults for the invert engine scheduler.
package invert_sched_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} sched_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LATENCY = 256;

endpackage

// File: rtl/invert_scheduler_if.sv
// Requester-side and engine-side signals of the invert scheduler.
interface invert_scheduler_if
    import invert_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] y_in;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       result;
    logic [ID_W-1:0]        result_id;
    logic                   busy;
    logic                   eng_start;
    logic [WIDTH-1:0]       eng_y;
    logic [WIDTH-1:0]       eng_x;

    modport master (
        output req, y_in, eng_x,
        input  ack, result, result_id, busy, eng_start, eng_y
    );

    modport slave (
        input  req, y_in, eng_x,
        output ack, result, result_id, busy, eng_start, eng_y
    );

endinterface

// File: rtl/invert_scheduler_arb.sv
// Combinational round-robin arbiter: the requester after last_grant has top priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] shift_s;
    logic [2*N-1:0]   rot_s;
    logic [SUM_W-1:0] enc_s;
    logic [SUM_W-1:0] sum_s;
    logic             found_s;

    // Rotate so last_grant+1 lands at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        shift_s = {1'b0, last_grant} + SUM_W'(1);
        rot_s   = {req, req} >> shift_s;
        enc_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot_s[i] && !found_s) begin
                found_s = 1'b1;
                enc_s   = SUM_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = enc_s + shift_s;
        if (sum_s >= SUM_W'(N)) begin
            sum_s = sum_s - SUM_W'(N);
        end else begin
            sum_s = sum_s;
        end
        grant_idx = sum_s[IDX_W-1:0];
        if (found_s) begin
            grant = N'(1) << grant_idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/invert_scheduler.sv
// Shares one fixed-latency invert engine among N_REQ requesters, round-robin,
// returning each result with a one-cycle ack.
module invert_scheduler
    import invert_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    invert_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

    sched_state_t      state_r;
    sched_state_t      state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ID_W-1:0]   last_grant_r;
    logic [ID_W-1:0]   result_id_r;
    logic [WIDTH-1:0]  eng_y_r;
    logic [WIDTH-1:0]  result_r;
    logic [N_REQ-1:0]  ack_r;
    logic              busy_r;
    logic [N_REQ-1:0]  grant_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [WIDTH-1:0]  y_sel_s;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (bus.req),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // Operand of the current winner.
    always_comb begin
        y_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                y_sel_s = bus.y_in[i*WIDTH +: WIDTH];
            end else begin
                y_sel_s = y_sel_s;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: state_next_s = WAIT;
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant latch, latency counter and result capture; the engine itself is never reset here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            last_grant_r <= ID_W'(N_REQ - 1);
            result_id_r  <= '0;
            eng_y_r      <= '0;
            result_r     <= '0;
            ack_r        <= '0;
            busy_r       <= 1'b0;
        end else begin
            ack_r  <= '0;
            busy_r <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        eng_y_r      <= y_sel_s;
                        result_id_r  <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                    end
                end
                LAUNCH: cnt_r <= CNT_W'(LATENCY);
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        result_r <= bus.eng_x;
                        ack_r    <= N_REQ'(1) << result_id_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign bus.eng_start = (state_r == LAUNCH);
    assign bus.eng_y     = eng_y_r;
    assign bus.ack       = ack_r;
    assign bus.result    = result_r;
    assign bus.result_id = result_id_r;
    assign bus.busy      = busy_r;

endmodule
